// File: rtl/score_display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : score_display_pkg
// Description : Shared definitions for the score display block: active-low
//               7-segment codes for decimal digits, the control FSM state
//               type and a helper giving the largest displayable value.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package score_display_pkg;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_CODE [0:9] = '{
      7'b1000000,   // 0
      7'b1111001,   // 1
      7'b0100100,   // 2
      7'b0110000,   // 3
      7'b0011001,   // 4
      7'b0010010,   // 5
      7'b0000010,   // 6
      7'b1111000,   // 7
      7'b0000000,   // 8
      7'b0010000    // 9
   };

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_LATCH = 2'd2
   } state_t;

   // 10^digits - 1, i.e. the largest value a display of that many digits shows
   function automatic logic [63:0] pow10_minus1(input int unsigned digits);
      logic [63:0] p;
      p = 64'd1;
      for (int unsigned n = 0; n < digits; n++) begin
         p = p * 64'd10;
      end
      return p - 64'd1;
   endfunction

   // Non-decimal nibbles never reach the display; show them as blank
   function automatic logic [6:0] seg_encode(input logic [3:0] d);
      if (d <= 4'd9) begin
         return SEG_CODE[d];
      end
      return SEG_BLANK;
   endfunction

endpackage
`default_nettype wire

// File: rtl/score_display_bin2bcd_serial.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_serial
// Description : Serial shift-and-add-3 (double-dabble) binary to BCD datapath.
//               Control comes from outside; one shift per shift_en cycle.
// Ports       : clk      - clock, rising edge
//               reset_n  - asynchronous active-low reset
//               start    - capture bin_in and clear the BCD register
//               shift_en - perform one add-3 correction + left shift
//               bin_in   - binary operand (BIN_W bits)
//               bcd_out  - BCD result, DIGITS nibbles, nibble 0 = units
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_serial #(
   parameter int BIN_W  = 10,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic                  shift_en,
   input  logic [BIN_W-1:0]      bin_in,
   output logic [4*DIGITS-1:0]   bcd_out
);

   localparam int BCD_W = 4 * DIGITS;

   logic [BIN_W-1:0] bin_sr;
   logic [BCD_W-1:0] bcd_sr;
   logic [BCD_W-1:0] bcd_adj;

   // A nibble >= 5 would become >= 10 after doubling; adding 3 first makes
   // the shift carry into the next decimal digit correctly.
   for (genvar n = 0; n < DIGITS; n++) begin : g_nibble
      assign bcd_adj[4*n +: 4] = (bcd_sr[4*n +: 4] >= 4'd5) ?
                                 (bcd_sr[4*n +: 4] + 4'd3) :
                                  bcd_sr[4*n +: 4];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bin_sr <= '0;
         bcd_sr <= '0;
      end else if (start) begin
         bin_sr <= bin_in;
         bcd_sr <= '0;
      end else if (shift_en) begin
         // {bcd, bin} shifted left as one long register
         bcd_sr <= {bcd_adj[BCD_W-2:0], bin_sr[BIN_W-1]};
         bin_sr <= bin_sr << 1;
      end
   end

   assign bcd_out = bcd_sr;

endmodule
`default_nettype wire

// File: rtl/score_display.sv
`default_nettype none
// ============================================================================
// Module      : score_display
// Description : Multi-digit active-low 7-segment score driver. A load request
//               starts a serial binary-to-BCD conversion; the result is
//               saturated to all 9s on overflow, optionally leading-zero
//               blanked and latched onto leds in one step, so the display
//               never shows intermediate values.
// Ports       : clk      - clock, rising edge
//               reset_n  - asynchronous active-low reset
//               load     - conversion request, honoured only when idle
//               value    - binary score, captured on an accepted load
//               busy     - conversion in progress
//               done     - one-cycle pulse when leds take the new pattern
//               overflow - last accepted value exceeded 10^DIGITS-1
//               leds     - digit i segments at [7i+6:7i], {g,f,e,d,c,b,a}
// Revision    : 1.0 - initial release
// ============================================================================
module score_display
   import score_display_pkg::*;
#(
   parameter int BIN_W    = 10,
   parameter int DIGITS   = 3,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  load,
   input  logic [BIN_W-1:0]      value,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   output logic [7*DIGITS-1:0]   leds
);

   localparam int               CNT_W    = $clog2(BIN_W + 1);
   localparam logic [63:0]      MAX_VAL  = pow10_minus1(DIGITS);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BIN_W);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t                state;
   state_t                state_next;
   logic                  start;
   logic                  shift_en;
   logic [CNT_W-1:0]      bit_cnt;
   logic                  ovf_pend;
   logic [4*DIGITS-1:0]   bcd;
   logic [4*DIGITS-1:0]   bcd_sat;
   logic [7*DIGITS-1:0]   leds_next;
   logic                  seen_nz;

   bin2bcd_serial #(
      .BIN_W  (BIN_W),
      .DIGITS (DIGITS)
   ) u_bin2bcd (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .shift_en (shift_en),
      .bin_in   (value),
      .bcd_out  (bcd)
   );

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      start      = 1'b0;
      shift_en   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (load) begin
               start      = 1'b1;
               state_next = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            shift_en = 1'b1;
            // The edge that consumes the last bit also leaves SHIFT
            if (bit_cnt == CNT_ONE) begin
               state_next = ST_LATCH;
            end
         end
         ST_LATCH: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------- bit counter, range check
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bit_cnt  <= '0;
         ovf_pend <= 1'b0;
      end else if (start) begin
         bit_cnt  <= CNT_INIT;
         // Decided once on the captured value; the BCD of an out-of-range
         // value is meaningless and gets replaced at latch time.
         ovf_pend <= (64'(value) > MAX_VAL);
      end else if (shift_en) begin
         bit_cnt  <= bit_cnt - CNT_ONE;
      end
   end

   // ------------------------------------- saturation, blanking, encoding
   assign bcd_sat = ovf_pend ? {DIGITS{4'd9}} : bcd;

   // Walk from the most significant digit down; a digit is shown once any
   // digit at or above it is non-zero. Digit 0 is always shown.
   always_comb begin
      leds_next = '1;
      seen_nz   = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         if (bcd_sat[4*i +: 4] != 4'd0) begin
            seen_nz = 1'b1;
         end
         if (!BLANK_LZ || (i == 0) || seen_nz) begin
            leds_next[7*i +: 7] = seg_encode(bcd_sat[4*i +: 4]);
         end
      end
   end

   // ------------------------------------------------ registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         leds     <= '1;
         overflow <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= (state == ST_LATCH);
         if (state == ST_LATCH) begin
            leds     <= leds_next;
            overflow <= ovf_pend;
         end
      end
   end

   assign busy = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_score_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_display
// Description : Self-checking bench for score_display. Two instances share
//               clock, reset and stimulus: one with leading-zero blanking,
//               one without. Expected patterns come from decimal arithmetic
//               on the requested value.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_display;

   localparam int BIN_W  = 10;
   localparam int DIGITS = 3;
   localparam int LAT    = BIN_W + 1;

   localparam logic [6:0] SEG [10] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };

   logic              clk;
   logic              reset_n;
   logic              load;
   logic [BIN_W-1:0]  value;
   logic              busy,     busy_nb;
   logic              done,     done_nb;
   logic              overflow, overflow_nb;
   logic [20:0]       leds,     leds_nb;

   int checks;
   int errors;

   // Model of what each display currently shows
   logic [20:0] exp_lz;
   logic [20:0] exp_nb;
   logic        exp_ovf;

   score_display #(.BIN_W(BIN_W), .DIGITS(DIGITS), .BLANK_LZ(1'b1)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (load),
      .value    (value),
      .busy     (busy),
      .done     (done),
      .overflow (overflow),
      .leds     (leds)
   );

   score_display #(.BIN_W(BIN_W), .DIGITS(DIGITS), .BLANK_LZ(1'b0)) dut_nb (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (load),
      .value    (value),
      .busy     (busy_nb),
      .done     (done_nb),
      .overflow (overflow_nb),
      .leds     (leds_nb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [20:0] model_leds(input int v, input bit blz);
      int          shown;
      int          p;
      int          dig;
      logic [20:0] r;
      shown = (v > 999) ? 999 : v;
      r     = '1;
      p     = 1;
      for (int i = 0; i < 3; i++) begin
         dig = (shown / p) % 10;
         if (!blz || i == 0 || shown >= p) begin
            r[7*i +: 7] = SEG[dig];
         end
         p = p * 10;
      end
      return r;
   endfunction

   // Starts at posedge+1; returns at posedge+1 of the done cycle.
   // intr_cycle >= 0 pulses a second load while busy.
   task automatic do_conversion(input int v, input int intr_cycle,
                                input int intr_val, input string tag);
      int   busy_cycles;
      int   n;
      bit   bad_mid;
      load  = 1'b1;
      value = BIN_W'(v);
      @(posedge clk); #1;
      load  = 1'b0;
      value = BIN_W'($urandom);
      busy_cycles = 0;
      n           = 0;
      bad_mid     = 1'b0;
      while (busy === 1'b1 && n < 40) begin
         if (done !== 1'b0 || leds !== exp_lz || leds_nb !== exp_nb)
            bad_mid = 1'b1;
         busy_cycles++;
         if (n == intr_cycle) begin
            load  = 1'b1;
            value = BIN_W'(intr_val);
         end else begin
            load  = 1'b0;
            value = BIN_W'($urandom);
         end
         @(posedge clk); #1;
         n++;
      end
      load = 1'b0;
      exp_lz  = model_leds(v, 1'b1);
      exp_nb  = model_leds(v, 1'b0);
      exp_ovf = (v > 999);

      checks++;
      if (bad_mid) begin
         errors++;
         $display("FAIL %s hold: leds/done changed during conversion", tag);
      end
      checks++;
      if (busy_cycles !== LAT) begin
         errors++;
         $display("FAIL %s busy_len: got %0d want %0d", tag, busy_cycles, LAT);
      end
      checks++;
      if (done !== 1'b1 || done_nb !== 1'b1) begin
         errors++;
         $display("FAIL %s done: got %b/%b want 1", tag, done, done_nb);
      end
      checks++;
      if (leds !== exp_lz) begin
         errors++;
         $display("FAIL %s leds: got %b want %b (value %0d)", tag, leds, exp_lz, v);
      end
      checks++;
      if (leds_nb !== exp_nb) begin
         errors++;
         $display("FAIL %s leds_nb: got %b want %b (value %0d)", tag, leds_nb, exp_nb, v);
      end
      checks++;
      if (overflow !== exp_ovf || overflow_nb !== exp_ovf) begin
         errors++;
         $display("FAIL %s overflow: got %b/%b want %b", tag, overflow, overflow_nb, exp_ovf);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      load    = 1'b0;
      value   = '0;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      exp_lz  = '1;
      exp_nb  = '1;
      exp_ovf = 1'b0;
      checks++;
      if (leds !== 21'h1FFFFF || leds_nb !== 21'h1FFFFF) begin
         errors++;
         $display("FAIL reset leds: got %b/%b want all ones", leds, leds_nb);
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset flags: busy=%b done=%b ovf=%b want 000", busy, done, overflow);
      end
   endtask

   task automatic test_zero();
      do_conversion(0, -1, 0, "zero");
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL done_width: got %b want 0 one cycle after pulse", done);
      end
   endtask

   task automatic test_basic();
      do_conversion(127, -1, 0, "v127");
      checks++;
      if (leds[20:14] !== 7'b1111001 || leds[13:7] !== 7'b0100100 ||
          leds[6:0] !== 7'b1111000) begin
         errors++;
         $display("FAIL v127 digits: got %b want 111100101001001111000", leds);
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_overflow();
      do_conversion(1023, -1, 0, "v1023");
      repeat (1) @(posedge clk);
      #1;
      do_conversion(5, -1, 0, "v5_after_ovf");
   endtask

   task automatic test_no_blank();
      @(posedge clk); #1;
      do_conversion(40, -1, 0, "v40");
   endtask

   task automatic test_back_to_back();
      @(posedge clk); #1;
      do_conversion(7, 3, 900, "v7_ignore900");
      // still in the done cycle: this load must be accepted
      do_conversion(900, -1, 0, "v900_done_cycle");
   endtask

   task automatic test_reset_mid();
      bit saw_done;
      @(posedge clk); #1;
      load  = 1'b1;
      value = BIN_W'(345);
      @(posedge clk); #1;
      load  = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      exp_lz  = '1;
      exp_nb  = '1;
      exp_ovf = 1'b0;
      checks++;
      if (leds !== 21'h1FFFFF || leds_nb !== 21'h1FFFFF || busy !== 1'b0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid async: leds=%b busy=%b ovf=%b want blank/0/0", leds, busy, overflow);
      end
      saw_done = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         if (done !== 1'b0) saw_done = 1'b1;
      end
      reset_n = 1'b1;
      repeat (LAT + 2) begin
         @(posedge clk); #1;
         if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
      end
      checks++;
      if (saw_done) begin
         errors++;
         $display("FAIL reset_mid: got done/busy activity after abort want none");
      end
      do_conversion(468, -1, 0, "after_reset");
   endtask

   task automatic test_random();
      int v;
      int gap;
      for (int k = 0; k < 15; k++) begin
         v   = int'($urandom_range(0, 1023));
         gap = int'($urandom_range(0, 2));
         repeat (gap) begin
            @(posedge clk); #1;
         end
         do_conversion(v, (k % 4 == 1) ? int'($urandom_range(0, 9)) : -1,
                       int'($urandom_range(0, 1023)), "random");
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_zero();
      test_basic();
      test_overflow();
      test_no_blank();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
